// File: rtl/fallthrough_fifo_reader_if.sv
// Bundle between a registered-output FIFO, the fall-through reader and its downstream consumer.
// The master modport is the reader; the slave modport is the FIFO/consumer side.
interface fallthrough_fifo_reader_if #(
   parameter int unsigned WIDTH       = 72,
   parameter int unsigned STATS_WIDTH = 32
);
   logic                   fifo_empty;
   logic                   fifo_rd_en;
   logic [WIDTH-1:0]       fifo_dout;
   logic [WIDTH-1:0]       out_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [1:0]             occupancy;
   logic [STATS_WIDTH-1:0] word_count;
   logic [STATS_WIDTH-1:0] stall_count;

   modport master (
      input  fifo_empty, fifo_dout, out_ready,
      output fifo_rd_en, out_data, out_valid, occupancy, word_count, stall_count
   );

   modport slave (
      output fifo_empty, fifo_dout, out_ready,
      input  fifo_rd_en, out_data, out_valid, occupancy, word_count, stall_count
   );
endinterface

// File: rtl/fallthrough_fifo_reader.sv
// Read-side adapter: turns a FIFO whose dout lags rd_en by one cycle into a fall-through stream.
// Delivery/stall counters are built only when FALLTHROUGH_FIFO_READER_STATS_EN is defined.
module fallthrough_fifo_reader #(
   parameter int unsigned WIDTH       = 72,
   parameter int unsigned STATS_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   fallthrough_fifo_reader_if.master bus
);
   localparam int unsigned OCC_W = 2;

   logic [WIDTH-1:0] head;
   logic [WIDTH-1:0] skid;
   logic [OCC_W-1:0] occ;
   logic [OCC_W-1:0] fill;
   logic [OCC_W-1:0] occ_next;
   logic             inflight;
   logic             pop;
   logic             rd_en;

   // fill counts buffered words plus the one in flight; it never exceeds 2.
   always_comb begin
      fill     = occ + OCC_W'(inflight);
      pop      = (occ != '0) & bus.out_ready;
      rd_en    = ~reset & ~bus.fifo_empty & ((fill < OCC_W'(2)) | pop);
      occ_next = fill - OCC_W'(pop);
   end

   assign bus.fifo_rd_en = rd_en;
   assign bus.out_valid  = (occ != '0);
   assign bus.out_data   = head;
   assign bus.occupancy  = occ;

   always_ff @(posedge clk) begin
      if (reset) begin
         occ      <= '0;
         inflight <= 1'b0;
      end else begin
         occ      <= occ_next;
         inflight <= rd_en;
      end
   end

   // head always holds the oldest word; skid holds the second when the consumer stalls.
   always_ff @(posedge clk) begin
      if (inflight) begin
         case (occ)
            OCC_W'(0): head <= bus.fifo_dout;
            OCC_W'(1): begin
               if (pop) head <= bus.fifo_dout;
               else     skid <= bus.fifo_dout;
            end
            OCC_W'(2): begin
               head <= skid;
               skid <= bus.fifo_dout;
            end
            default: ;
         endcase
      end else if (pop && (occ == OCC_W'(2))) begin
         head <= skid;
      end
   end

`ifdef FALLTHROUGH_FIFO_READER_STATS_EN
   logic [STATS_WIDTH-1:0] word_cnt;
   logic [STATS_WIDTH-1:0] stall_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         word_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         if (pop)                         word_cnt  <= word_cnt + STATS_WIDTH'(1);
         if (bus.out_valid & ~bus.out_ready) stall_cnt <= stall_cnt + STATS_WIDTH'(1);
      end
   end

   assign bus.word_count  = word_cnt;
   assign bus.stall_count = stall_cnt;
`else
   assign bus.word_count  = '0;
   assign bus.stall_count = '0;
`endif
endmodule

// File: tb/tb_fallthrough_fifo_reader.sv
// Bench for fallthrough_fifo_reader: bench-side FIFO, timestamped-word reference model,
// per-cycle compare at negedge, plus directed scenarios with literal expectations.
module tb_fallthrough_fifo_reader;
   localparam int unsigned W  = 72;
   localparam int unsigned SW = 32;
`ifdef FALLTHROUGH_FIFO_READER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   fallthrough_fifo_reader_if #(.WIDTH(W), .STATS_WIDTH(SW)) bus ();

   fallthrough_fifo_reader #(.WIDTH(W), .STATS_WIDTH(SW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [W-1:0] d;
      int           rdy;
   } ent_t;

   logic [W-1:0] fq[$];        // contents of the attached FIFO
   logic [W-1:0] dout_next;
   ent_t         mb[$];        // words popped from the FIFO and not yet delivered
   logic [W-1:0] del_q[$];     // delivered words
   int           del_cyc[$];
   int           rd_cyc[$];
   int           rd_cnt;
   int           cyc;
   int           wc, sc;
   int           pass_cnt, chk_cnt;

   task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      del_q.delete();
      del_cyc.delete();
      rd_cyc.delete();
      rd_cnt = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      fq.delete();
   endtask

   // Registered-output FIFO: the word popped in a cycle appears on dout in the next one.
   initial begin
      bus.fifo_empty = 1'b1;
      bus.fifo_dout  = '0;
      forever begin
         @(posedge clk);
         #2;
         bus.fifo_dout  = dout_next;
         bus.fifo_empty = (fq.size() == 0);
      end
   end

   // Reference model: a word read in cycle N is deliverable from N+2; at most 2 words owned.
   always @(negedge clk) begin
      int avail;
      bit ev, ep, erd;
      cyc++;
      if (reset) begin
         check("rd_en_in_reset", W'(bus.fifo_rd_en), W'(0));
         mb.delete();
         wc = 0;
         sc = 0;
      end else begin
         avail = 0;
         foreach (mb[i]) if (mb[i].rdy <= cyc) avail++;
         ev  = (avail != 0);
         ep  = ev && bus.out_ready;
         erd = !bus.fifo_empty && ((mb.size() < 2) || ep);
         check("out_valid", W'(bus.out_valid), W'(ev));
         check("occupancy", W'(bus.occupancy), W'(avail));
         check("fifo_rd_en", W'(bus.fifo_rd_en), W'(erd));
         if (ev) check("out_data", bus.out_data, mb[0].d);
         check("word_count", W'(bus.word_count), STATS ? W'(wc) : W'(0));
         check("stall_count", W'(bus.stall_count), STATS ? W'(sc) : W'(0));
         if (ev && !bus.out_ready) sc++;
         if (ep) begin
            del_q.push_back(mb[0].d);
            del_cyc.push_back(cyc);
            void'(mb.pop_front());
            wc++;
         end
         if (bus.fifo_rd_en) begin
            rd_cnt++;
            rd_cyc.push_back(cyc);
            if (fq.size() == 0) begin
               chk_cnt++;
               $display("FAIL fifo_read_empty: rd_en while FIFO empty (cycle %0d)", cyc);
            end else begin
               dout_next = fq.pop_front();
               mb.push_back('{d: dout_next, rdy: cyc + 2});
            end
         end
         check("owned_le_2", W'(mb.size() <= 2), W'(1));
      end
   end

   initial begin
      logic [W-1:0] exp_all[$];
      logic [W-1:0] w;
      int pushed, guard, mism;

      bus.out_ready = 1'b0;
      dout_next     = '0;
      reset         = 1'b1;
      clear_logs();
      tick(3);
      reset = 1'b0;
      check("rst_out_valid", W'(bus.out_valid), W'(0));
      check("rst_occupancy", W'(bus.occupancy), W'(0));
      check("rst_word_count", W'(bus.word_count), W'(0));
      check("rst_stall_count", W'(bus.stall_count), W'(0));

      // Single word
      clear_logs();
      bus.out_ready = 1'b1;
      fq.push_back(W'(8'hA5));
      tick(8);
      check("single_rd_pulses", W'(rd_cnt), W'(1));
      check("single_delivered", W'(del_q.size()), W'(1));
      if (del_q.size() >= 1 && rd_cyc.size() >= 1) begin
         check("single_data", del_q[0], W'(8'hA5));
         check("single_latency", W'(del_cyc[0] - rd_cyc[0]), W'(2));
      end
      check("single_occ_idle", W'(bus.occupancy), W'(0));

      // Streaming 16 words
      do_reset();
      clear_logs();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 16; i++) fq.push_back(W'(i));
      tick(24);
      check("stream_count", W'(del_q.size()), W'(16));
      if (del_q.size() == 16 && rd_cyc.size() >= 1) begin
         for (int i = 0; i < 16; i++) check("stream_data", del_q[i], W'(i));
         check("stream_span", W'(del_cyc[15] - del_cyc[0]), W'(15));
         check("stream_latency", W'(del_cyc[0] - rd_cyc[0]), W'(2));
      end
      check("stream_word_count", W'(bus.word_count), STATS ? W'(16) : W'(0));
      check("stream_stall_count", W'(bus.stall_count), W'(0));

      // Backpressure: 10 cycles with out_valid high and out_ready low
      do_reset();
      clear_logs();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 8; i++) fq.push_back(W'(i));
      tick(2);
      check("bp_valid_up", W'(bus.out_valid), W'(1));
      tick(10);
      check("bp_rd_during_stall", W'(rd_cnt), W'(2));
      check("bp_occupancy", W'(bus.occupancy), W'(2));
      check("bp_held_data", bus.out_data, W'(0));
      check("bp_stall_count", W'(bus.stall_count), STATS ? W'(10) : W'(0));
      bus.out_ready = 1'b1;
      tick(20);
      check("bp_count", W'(del_q.size()), W'(8));
      if (del_q.size() == 8)
         for (int i = 0; i < 8; i++) check("bp_data", del_q[i], W'(i));
      check("bp_stall_final", W'(bus.stall_count), STATS ? W'(10) : W'(0));

      // Random backpressure and random refill over 1000 words
      do_reset();
      clear_logs();
      exp_all.delete();
      pushed = 0;
      guard  = 0;
      while (del_q.size() < 1000 && guard < 20000) begin
         bus.out_ready = 1'($urandom_range(0, 1));
         if (pushed < 1000 && fq.size() < 6 && $urandom_range(0, 1) == 1) begin
            w = W'({$urandom, $urandom, $urandom});
            fq.push_back(w);
            exp_all.push_back(w);
            pushed++;
         end
         tick(1);
         guard++;
      end
      check("random_delivered", W'(del_q.size()), W'(1000));
      mism = 0;
      for (int i = 0; i < del_q.size() && i < exp_all.size(); i++)
         if (del_q[i] !== exp_all[i]) mism++;
      check("random_order", W'(mism), W'(0));

      // Reset while the buffer and the read pipeline are both occupied
      do_reset();
      clear_logs();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) fq.push_back(W'(100 + i));
      tick(2);
      check("pre_reset_occ", W'(bus.occupancy), W'(1));
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      fq.delete();
      check("post_reset_valid", W'(bus.out_valid), W'(0));
      check("post_reset_occ", W'(bus.occupancy), W'(0));
      check("post_reset_words", W'(bus.word_count), W'(0));
      check("post_reset_stalls", W'(bus.stall_count), W'(0));
      clear_logs();
      bus.out_ready = 1'b1;
      fq.push_back(W'(8'h3C));
      tick(6);
      check("refill_count", W'(del_q.size()), W'(1));
      if (del_q.size() >= 1) check("refill_first", del_q[0], W'(8'h3C));

      tick(2);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
